// File: rtl/truth_table_scanner_if.sv
// Control, status and unit-side signals of the truth table scanner.
// master = test/config side plus unit under test, slave = scanner.
interface truth_table_scanner_if #(
  parameter int N_IN = 5
);
  localparam int W = 1 << N_IN;

  logic            start;
  logic            abort;
  logic [W-1:0]    exp_table;
  logic            f_in;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic [W-1:0]    table_out;
  logic [N_IN:0]   ones_count;
  logic            table_valid;
  logic            mismatch;
  logic [N_IN-1:0] first_fail;

  modport master (
    output start, abort, exp_table, f_in,
    input  vec_out, busy, done, table_out,
    input  ones_count, table_valid,
    input  mismatch, first_fail
  );

  modport slave (
    input  start, abort, exp_table, f_in,
    output vec_out, busy, done, table_out,
    output ones_count, table_valid,
    output mismatch, first_fail
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Sweeps every input vector of a combinational unit, samples its
// output, and builds/compares the full truth table.
module truth_table_scanner #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 1
) (
  input logic clk,
  input logic rst_n,
  truth_table_scanner_if.slave bus
);
  localparam int W  = 1 << N_IN;
  localparam int WW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [WW-1:0]   w_q, w_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    tab_q, tab_d;
  logic [W-1:0]    exp_q, exp_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic [N_IN-1:0] ff_q, ff_d;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    w_d     = w_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tab_d   = tab_q;
    exp_d   = exp_q;
    ones_d  = ones_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    ff_d    = ff_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          exp_d   = bus.exp_table;
          tab_d   = '0;
          ones_d  = '0;
          mis_d   = 1'b0;
          ff_d    = '0;
          valid_d = 1'b0;
          vec_d   = '0;
          w_d     = WW'(SETTLE);
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          vec_d   = '0;
        end else if (w_q != '0) begin
          w_d = w_q - WW'(1);
        end else begin
          tab_d[vec_q] = bus.f_in;
          ones_d = ones_q + (N_IN+1)'(bus.f_in);
          // Only the lowest failing vector is kept.
          if (bus.f_in != exp_q[vec_q] && !mis_q) begin
            ff_d  = vec_q;
            mis_d = 1'b1;
          end
          if (vec_q == {N_IN{1'b1}}) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b1;
            vec_d   = '0;
          end else begin
            vec_d = vec_q + N_IN'(1);
            w_d   = WW'(SETTLE);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tab_q   <= '0;
      exp_q   <= '0;
      ones_q  <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tab_q   <= tab_d;
      exp_q   <= exp_d;
      ones_q  <= ones_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      ff_q    <= ff_d;
    end
  end

  assign bus.vec_out     = vec_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.table_out   = tab_q;
  assign bus.ones_count  = ones_q;
  assign bus.table_valid = valid_q;
  assign bus.mismatch    = mis_q;
  assign bus.first_fail  = ff_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: three scanners (SETTLE 1, 0, 3) driven by
// directed unit functions; a monitor checks each done pulse.
module tb_truth_table_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tab;
    logic [5:0]  ones;
    logic        mis;
    logic [4:0]  ff;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_chk = 0;
  int n_pass = 0;
  int ecnt = 0;
  int st_edge[3];
  int mode[3];
  logic        start_r[3];
  logic        abort_r[3];
  logic [31:0] exp_r[3];
  logic [1:0]  hc = '0;

  logic        busy_w[3], done_w[3];
  logic        valid_w[3], mis_w[3];
  logic [4:0]  vec_w[3], ff_w[3];
  logic [5:0]  ones_w[3];
  logic [31:0] tab_w[3];

  truth_table_scanner_if #(.N_IN(5)) if0 ();
  truth_table_scanner_if #(.N_IN(5)) if1 ();
  truth_table_scanner_if #(.N_IN(5)) if2 ();

  truth_table_scanner #(.N_IN(5), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  truth_table_scanner #(.N_IN(5), .SETTLE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  truth_table_scanner #(.N_IN(5), .SETTLE(3)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));

  function automatic logic ufn(int m, logic [4:0] v);
    case (m)
      0: return v[0];
      1: return &v;
      2: return 1'b1;
      default: return v[0] ^ ((v == 5'd5) || (v == 5'd9));
    endcase
  endfunction

  assign if0.start = start_r[0];
  assign if1.start = start_r[1];
  assign if2.start = start_r[2];
  assign if0.abort = abort_r[0];
  assign if1.abort = abort_r[1];
  assign if2.abort = abort_r[2];
  assign if0.exp_table = exp_r[0];
  assign if1.exp_table = exp_r[1];
  assign if2.exp_table = exp_r[2];
  assign if0.f_in = ufn(mode[0], if0.vec_out);
  assign if1.f_in = ufn(mode[1], if1.vec_out);
  // Correct value only on the final hold cycle of each vector.
  assign if2.f_in = (hc == 2'd3) ? ufn(mode[2], if2.vec_out)
                                 : ~ufn(mode[2], if2.vec_out);

  assign busy_w[0] = if0.busy;
  assign busy_w[1] = if1.busy;
  assign busy_w[2] = if2.busy;
  assign done_w[0] = if0.done;
  assign done_w[1] = if1.done;
  assign done_w[2] = if2.done;
  assign valid_w[0] = if0.table_valid;
  assign valid_w[1] = if1.table_valid;
  assign valid_w[2] = if2.table_valid;
  assign mis_w[0] = if0.mismatch;
  assign mis_w[1] = if1.mismatch;
  assign mis_w[2] = if2.mismatch;
  assign vec_w[0] = if0.vec_out;
  assign vec_w[1] = if1.vec_out;
  assign vec_w[2] = if2.vec_out;
  assign ff_w[0] = if0.first_fail;
  assign ff_w[1] = if1.first_fail;
  assign ff_w[2] = if2.first_fail;
  assign ones_w[0] = if0.ones_count;
  assign ones_w[1] = if1.ones_count;
  assign ones_w[2] = if2.ones_count;
  assign tab_w[0] = if0.table_out;
  assign tab_w[1] = if1.table_out;
  assign tab_w[2] = if2.table_out;

  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    if (start_r[2] && !busy_w[2]) hc <= 2'd0;
    else hc <= hc + 2'd1;
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_zero(int d, string name);
    chk(name, {busy_w[d], done_w[d], valid_w[d], mis_w[d],
               vec_w[d], ff_w[d], ones_w[d], tab_w[d]}, 64'd0);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_n && done_w[d]) begin
        int sz;
        exp_t e;
        sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: dut %0d got done, expected none", d);
        end else begin
          case (d)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          chk($sformatf("latency%0d", d), ecnt - st_edge[d], e.lat);
          chk($sformatf("table%0d", d), tab_w[d], e.tab);
          chk($sformatf("ones%0d", d), ones_w[d], e.ones);
          chk($sformatf("mismatch%0d", d), mis_w[d], e.mis);
          chk($sformatf("first_fail%0d", d), ff_w[d], e.ff);
          chk($sformatf("valid%0d", d), valid_w[d], 1'b1);
          chk($sformatf("busy_at_done%0d", d), busy_w[d], 1'b0);
        end
      end
    end
  end

  task automatic pulse_start(int d, bit rec);
    @(negedge clk);
    start_r[d] = 1'b1;
    @(negedge clk);
    start_r[d] = 1'b0;
    if (rec) st_edge[d] = ecnt;
  endtask

  task automatic wait_idle(int d, int lim);
    int n = 0;
    while (busy_w[d] && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (busy_w[d]) begin
      n_chk++;
      $display("FAIL timeout: dut %0d busy after %0d cycles, expected idle", d, lim);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_scan(int d, int m, logic [31:0] et,
                          logic [31:0] tab, logic [5:0] ones,
                          logic mis, logic [4:0] ff, int lat,
                          bit mid_start);
    exp_t e;
    e.tab = tab; e.ones = ones; e.mis = mis; e.ff = ff; e.lat = lat;
    mode[d] = m;
    exp_r[d] = et;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    pulse_start(d, 1'b1);
    if (mid_start) begin
      repeat (20) @(negedge clk);
      exp_r[d] = 32'h0;
      pulse_start(d, 1'b0);
      exp_r[d] = et;
    end
    wait_idle(d, lat + 20);
  endtask

  initial begin
    int n;
    for (int d = 0; d < 3; d++) begin
      start_r[d] = 1'b0;
      abort_r[d] = 1'b0;
      exp_r[d] = 32'h0;
      mode[d] = 0;
      st_edge[d] = 0;
    end
    repeat (3) @(negedge clk);
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    chk_zero(2, "reset2");
    rst_n = 1'b1;
    @(negedge clk);

    run_scan(0, 0, 32'hAAAAAAAA, 32'hAAAAAAAA, 6'd16, 1'b0, 5'd0, 64, 0);
    run_scan(0, 1, 32'h80000000, 32'h80000000, 6'd1, 1'b0, 5'd0, 64, 0);
    run_scan(0, 2, 32'h80000000, 32'hFFFFFFFF, 6'd32, 1'b1, 5'd0, 64, 0);
    run_scan(0, 3, 32'hAAAAAAAA, 32'hAAAAA88A, 6'd14, 1'b1, 5'd5, 64, 0);
    run_scan(1, 0, 32'hAAAAAAAA, 32'hAAAAAAAA, 6'd16, 1'b0, 5'd0, 32, 0);
    run_scan(2, 0, 32'hAAAAAAAA, 32'hAAAAAAAA, 6'd16, 1'b0, 5'd0, 128, 0);
    run_scan(0, 0, 32'hAAAAAAAA, 32'hAAAAAAAA, 6'd16, 1'b0, 5'd0, 64, 1);

    mode[0] = 0;
    exp_r[0] = 32'hAAAAAAAA;
    pulse_start(0, 1'b1);
    n = 0;
    while (vec_w[0] != 5'd10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec10", vec_w[0], 5'd10);
    abort_r[0] = 1'b1;
    @(negedge clk);
    abort_r[0] = 1'b0;
    chk("abort_busy", busy_w[0], 1'b0);
    chk("abort_vec", vec_w[0], 5'd0);
    chk("abort_valid", valid_w[0], 1'b0);
    chk("abort_ones", ones_w[0], 6'd5);
    repeat (80) @(negedge clk);
    chk("abort_idle_busy", busy_w[0], 1'b0);
    run_scan(0, 0, 32'hAAAAAAAA, 32'hAAAAAAAA, 6'd16, 1'b0, 5'd0, 64, 0);

    pulse_start(0, 1'b1);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero(0, "mid_reset");
    start_r[0] = 1'b1;
    abort_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    abort_r[0] = 1'b0;
    chk("start_abort_busy", busy_w[0], 1'b0);
    repeat (80) @(negedge clk);
    chk_zero(0, "start_abort_idle");

    chk("queue_empty", q0.size() + q1.size() + q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
